// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow error flags. Synchronous active-high reset.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (head word shown
// combinationally); leave undefined for a registered read with one cycle of latency.
module sync_fifo_flags #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_LEVEL  = DEPTH - 2,
  parameter int unsigned AE_LEVEL  = 2,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 rvalid_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o,
  input  logic                 err_clr_i
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 wr_error_q, wr_error_d;
  logic                 rd_error_q, rd_error_d;
  logic                 full, empty;
  logic                 wr_accept, rd_accept;

  // Status flags decoded from the registered count only, so there is no same-cycle bypass.
  always_comb begin
    full           = (count_q == CNT_WIDTH'(DEPTH));
    empty          = (count_q == '0);
    almost_full_o  = (count_q >= CNT_WIDTH'(AF_LEVEL));
    almost_empty_o = (count_q <= CNT_WIDTH'(AE_LEVEL));
    full_o         = full;
    empty_o        = empty;
    count_o        = count_q;
    wr_error_o     = wr_error_q;
    rd_error_o     = rd_error_q;
    wr_accept      = wr_en_i && !full;
    rd_accept      = rd_en_i && !empty;
  end

  // Next-state for pointers, occupancy and the sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
    end
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    // A fresh error in the same cycle as a clear keeps the flag set.
    wr_error_d = (wr_en_i && full)  ? 1'b1 : (err_clr_i ? 1'b0 : wr_error_q);
    rd_error_d = (rd_en_i && empty) ? 1'b1 : (err_clr_i ? 1'b0 : rd_error_q);
  end

  // Storage array: written on accepted writes, never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_accept) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_error_q <= wr_error_d;
      rd_error_q <= rd_error_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shown directly; forced to zero while empty so reset leaves rdata_o at 0.
  always_comb begin
    rvalid_o = !empty;
    rdata_o  = empty ? '0 : mem[rd_ptr_q];
  end
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  // Registered read: data appears the cycle after an accepted read and then holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_accept;
      if (rd_accept) begin
        rdata_q <= mem[rd_ptr_q];
      end
    end
  end

  // Drive outputs from the read registers.
  always_comb begin
    rdata_o  = rdata_q;
    rvalid_o = rvalid_q;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags (WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
// The reference model is a plain queue of words plus two error bits.
module tb_sync_fifo_flags;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, err_clr;
  logic [W-1:0]  wdata, rdata;
  logic          rvalid, full, empty, afull, aempty, wr_err, rd_err;
  logic [3:0]    count;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .WIDTH   (W),
    .DEPTH   (D),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_en_i       (wr_en),
    .wdata_i       (wdata),
    .rd_en_i       (rd_en),
    .rdata_o       (rdata),
    .rvalid_o      (rvalid),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (afull),
    .almost_empty_o(aempty),
    .count_o       (count),
    .wr_error_o    (wr_err),
    .rd_error_o    (rd_err),
    .err_clr_i     (err_clr)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [W-1:0] model_q[$];  // words held by the reference FIFO, head first
  logic [W-1:0] exp_q[$];    // read data the DUT still owes the monitor
  logic         m_wr_err = 1'b0;
  logic         m_rd_err = 1'b0;
  logic         m_rvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int unsigned n;
    n = model_q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == D));
    chk("almost_full", 32'(afull), 32'(n >= AF));
    chk("almost_empty", 32'(aempty), 32'(n <= AE));
    chk("wr_error", 32'(wr_err), 32'(m_wr_err));
    chk("rd_error", 32'(rd_err), 32'(m_rd_err));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rvalid_fwft", 32'(rvalid), 32'(n != 0));
    if (n != 0) chk("rdata_fwft", 32'(rdata), 32'(model_q[0]));
`else
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
`endif
  endtask

  // One clock of stimulus: model decides acceptance from its occupancy before the edge.
  task automatic step(input logic wr, input logic [W-1:0] wd, input logic rd,
                      input logic clr, input logic rs);
    bit wacc, racc;
    wr_en = wr; wdata = wd; rd_en = rd; err_clr = clr; rst = rs;
    if (rs) begin
      model_q.delete();
      m_wr_err = 1'b0;
      m_rd_err = 1'b0;
      m_rvalid = 1'b0;
    end else begin
      wacc = wr && (model_q.size() < D);
      racc = rd && (model_q.size() > 0);
      if (racc) begin
`ifndef SYNC_FIFO_FWFT_EN
        exp_q.push_back(model_q[0]);
`endif
        void'(model_q.pop_front());
      end
      if (wacc) model_q.push_back(wd);
      m_wr_err = (wr && !wacc) ? 1'b1 : (clr ? 1'b0 : m_wr_err);
      m_rd_err = (rd && !racc) ? 1'b1 : (clr ? 1'b0 : m_rd_err);
      m_rvalid = racc;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    check_flags();
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  // Monitor: every rvalid cycle must deliver the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("rvalid_spurious", 32'(rvalid), 32'd0);
      else chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end
  end
`endif

  initial begin
    int unsigned bias;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wdata = '0;

    // Reset then idle.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rdata_reset", 32'(rdata), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill to full, walking every threshold.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);

    // Write while full with a simultaneous read: write rejected, read proceeds.
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("count_after_full_rw", 32'(count), 32'd7);

    // Drain, then clear the write error.
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Interleaved traffic across the pointer wrap at constant occupancy.
    step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, W'(16'h0100 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Read while empty together with a clear: new error wins, then a lone clear drops it.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("rd_error_set_wins", 32'(rd_err), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset at count 5, then a fresh word round-trips.
    for (int i = 0; i < 5; i++) step(1'b1, W'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // FWFT head visibility straight after a write into an empty FIFO.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with a drifting write/read bias to reach both full and empty.
    bias = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) bias = $urandom_range(15, 85);
      step(($urandom_range(0, 99) < bias), W'($urandom),
           ($urandom_range(0, 99) >= bias), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) == 0));
    end

    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
